// File: rtl/pdp_mem_responder_if.sv
// Purpose : request/response bundle between the fetch/write-back stages and pdp_mem_responder.
// Latency : n/a (signal bundle only).
// Backpressure: requesters hold req/addr/data until their ack pulse; one access in flight.
// Ports: fetch_req/fetch_addr -> fetch_ack/fetch_data, wb_req/wb_addr/wb_data/wb_byte -> wb_ack,
//        bus_error qualifies either ack.
interface pdp_mem_responder_if;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic        fetch_ack;
   logic [15:0] fetch_data;
   logic        wb_req;
   logic [15:0] wb_addr;
   logic [15:0] wb_data;
   logic        wb_byte;
   logic        wb_ack;
   logic        bus_error;

   // requester side (pipeline stages)
   modport master (
      output fetch_req, fetch_addr, wb_req, wb_addr, wb_data, wb_byte,
      input  fetch_ack, fetch_data, wb_ack, bus_error
   );

   // responder side (memory)
   modport slave (
      input  fetch_req, fetch_addr, wb_req, wb_addr, wb_data, wb_byte,
      output fetch_ack, fetch_data, wb_ack, bus_error
   );
endinterface

// File: rtl/pdp_mem_responder.sv
// Purpose : single-port 16-bit word memory serving instruction fetch and write-back, write-back first.
// Latency : ack WAIT_CYCLES+1 cycles after the request cycle; next grant in the cycle after the ack.
// Backpressure: one access in flight; a pending requester simply waits with req held until its ack.
// Ports   : clock, reset_n (async, active-low), bus (pdp_mem_responder_if.slave).
// Params  : MEM_WORDS (2..32768 words), WAIT_CYCLES (0..7 added latency).
// Option  : define PDP_MEM_BUS_ERROR_EN to reject odd word/fetch addresses and out-of-range words.
module pdp_mem_responder #(
   parameter int unsigned MEM_WORDS   = 4096,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic               clock,
   input  logic               reset_n,
   pdp_mem_responder_if.slave bus
);
   localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [2:0]  WAIT_LOAD = 3'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, FETCH_WAIT, WB_WAIT, RESPOND} state_t;

   typedef struct packed {
      logic        is_wr;
      logic        is_byte;
      logic [15:0] addr;
      logic [15:0] data;
   } acc_t;

   state_t           state;
   logic [2:0]       wait_cnt;
   acc_t             acc_q;
   acc_t             grant_acc;
   acc_t             cur_acc;
   logic             grant;
   logic             fire;
   logic             reject;
   logic             mem_we;
   logic             wr_lo;
   logic             wr_hi;
   logic [7:0]       hi_val;
   logic [IDX_W-1:0] cur_idx;
   logic             fetch_ack_q;
   logic             wb_ack_q;
   logic [15:0]      fetch_data_q;

   logic [15:0]      mem [MEM_WORDS];

   // Arbitration: write-back wins; a losing fetch keeps its req up and is taken next IDLE.
   always_comb begin
      grant_acc = '0;
      if (bus.wb_req) begin
         grant_acc.is_wr   = 1'b1;
         grant_acc.is_byte = bus.wb_byte;
         grant_acc.addr    = bus.wb_addr;
         grant_acc.data    = bus.wb_data;
      end else begin
         grant_acc.addr    = bus.fetch_addr;
      end
   end

   assign grant = (state == IDLE) && (bus.wb_req || bus.fetch_req);

   // fire marks the edge that enters RESPOND. With no wait states that is the grant edge
   // itself, so the live request is used; otherwise the copy latched at grant.
   assign fire    = (WAIT_CYCLES == 0) ? grant
                  : (((state == FETCH_WAIT) || (state == WB_WAIT)) && (wait_cnt == 3'd1));
   assign cur_acc = (state == IDLE) ? grant_acc : acc_q;
   assign cur_idx = IDX_W'({17'd0, cur_acc.addr[15:1]} % MEM_WORDS);

`ifdef PDP_MEM_BUS_ERROR_EN
   // Only byte writes may use an odd address; the word index must lie inside the array.
   assign reject = (~(cur_acc.is_wr & cur_acc.is_byte) & cur_acc.addr[0])
                 | ({17'd0, cur_acc.addr[15:1]} >= MEM_WORDS);
`else
   assign reject = 1'b0;
`endif

   // reset_n gates the write so an access aborted by reset never reaches the array.
   assign mem_we = fire & reset_n & cur_acc.is_wr & ~reject;
   assign wr_lo  = mem_we & (~cur_acc.is_byte | ~cur_acc.addr[0]);
   assign wr_hi  = mem_we & (~cur_acc.is_byte |  cur_acc.addr[0]);
   // Byte writes always carry their byte in data[7:0], whichever lane it lands in.
   assign hi_val = cur_acc.is_byte ? cur_acc.data[7:0] : cur_acc.data[15:8];

   // Array has no reset: contents survive reset_n.
   always_ff @(posedge clock) begin
      if (wr_lo) mem[cur_idx][7:0]  <= cur_acc.data[7:0];
      if (wr_hi) mem[cur_idx][15:8] <= hi_val;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         wait_cnt     <= 3'd0;
         acc_q        <= '0;
         fetch_ack_q  <= 1'b0;
         wb_ack_q     <= 1'b0;
         fetch_data_q <= 16'h0000;
      end else begin
         fetch_ack_q <= 1'b0;
         wb_ack_q    <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  acc_q <= grant_acc;
                  if (WAIT_CYCLES == 0) begin
                     state <= RESPOND;
                  end else begin
                     state    <= grant_acc.is_wr ? WB_WAIT : FETCH_WAIT;
                     wait_cnt <= WAIT_LOAD;
                  end
               end
            end
            FETCH_WAIT, WB_WAIT: begin
               if (wait_cnt == 3'd1) begin
                  state    <= RESPOND;
                  wait_cnt <= 3'd0;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            RESPOND: state <= IDLE;
            default: state <= IDLE;
         endcase

         // Acks are registered on the RESPOND entry edge, so they are high exactly during RESPOND.
         if (fire) begin
            if (cur_acc.is_wr) begin
               wb_ack_q <= 1'b1;
            end else begin
               fetch_ack_q  <= 1'b1;
               fetch_data_q <= reject ? 16'h0000 : mem[cur_idx];
            end
         end
      end
   end

`ifdef PDP_MEM_BUS_ERROR_EN
   logic bus_error_q;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) bus_error_q <= 1'b0;
      else          bus_error_q <= fire & reject;
   end
   assign bus.bus_error = bus_error_q;
`else
   assign bus.bus_error = 1'b0;
`endif

   assign bus.fetch_ack  = fetch_ack_q;
   assign bus.wb_ack     = wb_ack_q;
   assign bus.fetch_data = fetch_data_q;
endmodule

// File: tb/tb_pdp_mem_responder.sv
// Purpose : bench for pdp_mem_responder; dut0 runs WAIT_CYCLES=1, dut1 runs WAIT_CYCLES=3.
// Latency : expectations keyed by absolute cycle (request cycle + WAIT_CYCLES + 1).
// Backpressure: driver issues one access at a time and holds req until the ack is observed.
module tb_pdp_mem_responder;
   localparam int MEM    = 4096;
   localparam int STRIDE = 100000;

   typedef struct packed {
      logic        fack;
      logic        wack;
      logic        berr;
      logic [15:0] fdata;
   } ev_t;

   logic clock;
   logic rst0_n;
   logic rst1_n;
   int   cyc;
   int   tests;
   int   fails;

   ev_t         ev [int];     // expected ack events, key = dut*STRIDE + ack cycle
   logic [15:0] mm [int];     // model memory, key = dut*65536 + word index
   logic [15:0] exp_fd [2];

   pdp_mem_responder_if bus0 ();
   pdp_mem_responder_if bus1 ();

   pdp_mem_responder #(.MEM_WORDS(MEM), .WAIT_CYCLES(1)) dut0 (
      .clock(clock), .reset_n(rst0_n), .bus(bus0));
   pdp_mem_responder #(.MEM_WORDS(MEM), .WAIT_CYCLES(3)) dut1 (
      .clock(clock), .reset_n(rst1_n), .bus(bus1));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial cyc = 0;
   always @(posedge clock) cyc = cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endfunction

   function automatic logic fack_of(input int d);
      return (d == 0) ? bus0.fetch_ack : bus1.fetch_ack;
   endfunction
   function automatic logic wack_of(input int d);
      return (d == 0) ? bus0.wb_ack : bus1.wb_ack;
   endfunction
   function automatic logic berr_of(input int d);
      return (d == 0) ? bus0.bus_error : bus1.bus_error;
   endfunction
   function automatic logic [15:0] fdata_of(input int d);
      return (d == 0) ? bus0.fetch_data : bus1.fetch_data;
   endfunction

   // Behavioural model: apply the access to the model memory and book its ack outcome.
   function automatic void model_access(input int d, input int req_cyc, input bit wr, input bit byt,
                                        input logic [15:0] addr, input logic [15:0] data);
      int          w;
      int          key;
      bit          rej;
      logic [15:0] word;
      ev_t         e;
      w   = (d == 0) ? 1 : 3;
      key = d * 65536 + (int'(addr[15:1]) % MEM);
      rej = 1'b0;
`ifdef PDP_MEM_BUS_ERROR_EN
      rej = ((!(wr && byt)) && addr[0]) || (int'(addr[15:1]) >= MEM);
`endif
      e = '0;
      e.berr = rej;
      if (wr) begin
         e.wack = 1'b1;
         if (!rej) begin
            word = mm.exists(key) ? mm[key] : 16'h0000;
            if (!byt)        word = data;
            else if (addr[0]) word[15:8] = data[7:0];
            else             word[7:0]  = data[7:0];
            mm[key] = word;
         end
      end else begin
         e.fack  = 1'b1;
         e.fdata = rej ? 16'h0000 : mm[key];
      end
      ev[d * STRIDE + req_cyc + w + 1] = e;
   endfunction

   // Per-cycle compare of every output of both DUTs against the model.
   always @(negedge clock) begin
      for (int d = 0; d < 2; d++) begin
         ev_t e;
         bit  rn;
         e  = '0;
         if (ev.exists(d * STRIDE + cyc)) e = ev[d * STRIDE + cyc];
         rn = (d == 0) ? rst0_n : rst1_n;
         if (!rn)        exp_fd[d] = 16'h0000;
         else if (e.fack) exp_fd[d] = e.fdata;
         check($sformatf("d%0d.fetch_ack", d),  {31'd0, fack_of(d)}, {31'd0, e.fack & rn});
         check($sformatf("d%0d.wb_ack", d),     {31'd0, wack_of(d)}, {31'd0, e.wack & rn});
         check($sformatf("d%0d.bus_error", d),  {31'd0, berr_of(d)}, {31'd0, e.berr & rn});
         check($sformatf("d%0d.fetch_data", d), {16'd0, fdata_of(d)}, {16'd0, exp_fd[d]});
      end
   end

   task automatic drive(input int d, input bit fr, input logic [15:0] fa, input bit wq,
                        input logic [15:0] wa, input logic [15:0] wd, input bit wb);
      if (d == 0) begin
         bus0.fetch_req = fr; bus0.fetch_addr = fa;
         bus0.wb_req = wq; bus0.wb_addr = wa; bus0.wb_data = wd; bus0.wb_byte = wb;
      end else begin
         bus1.fetch_req = fr; bus1.fetch_addr = fa;
         bus1.wb_req = wq; bus1.wb_addr = wa; bus1.wb_data = wd; bus1.wb_byte = wb;
      end
   endtask

   task automatic wait_ack(input int d, input bit wr, input string tag,
                           output int ac, output logic [15:0] rd, output logic be);
      bit seen;
      seen = 1'b0;
      ac   = -1;
      rd   = 16'h0000;
      be   = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clock);
         if (wr ? wack_of(d) : fack_of(d)) begin
            seen = 1'b1;
            ac   = cyc;
            rd   = fdata_of(d);
            be   = berr_of(d);
         end
      end
      check({tag, "_ack_seen"}, {31'd0, seen}, 32'd1);
   endtask

   // Issue one access in the current cycle, wait for its ack, release req in the following cycle.
   task automatic do_req(input int d, input bit wr, input bit byt, input logic [15:0] addr,
                         input logic [15:0] data, input bit early_drop, input string tag,
                         output int rc, output int ac, output logic [15:0] rd, output logic be);
      if (wr) drive(d, 1'b0, 16'h0000, 1'b1, addr, data, byt);
      else    drive(d, 1'b1, addr, 1'b0, 16'h0000, 16'h0000, 1'b0);
      rc = cyc;
      model_access(d, rc, wr, byt, addr, data);
      if (early_drop) begin
         @(posedge clock); #1;
         drive(d, 1'b0, 16'hFFFF, 1'b0, 16'hFFFE, 16'hDEAD, ~byt);
      end
      wait_ack(d, wr, tag, ac, rd, be);
      @(posedge clock); #1;
      drive(d, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int          rc;
      int          ac;
      int          a1;
      int          a2;
      logic [15:0] rd;
      logic        be;
      tests     = 0;
      fails     = 0;
      exp_fd[0] = 16'h0000;
      exp_fd[1] = 16'h0000;
      rst0_n    = 1'b0;
      rst1_n    = 1'b0;
      drive(0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
      drive(1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
      repeat (3) @(posedge clock);
      #1;
      rst0_n = 1'b1;
      rst1_n = 1'b1;
      @(posedge clock); #1;

      // Basic fetch: mem[2]=1234, fetch 0x0004, ack two cycles after the request cycle.
      do_req(0, 1'b1, 1'b0, 16'h0004, 16'h1234, 1'b0, "wr_1234", rc, ac, rd, be);
      check("wr_latency", 32'(ac - rc), 32'd2);
      do_req(0, 1'b0, 1'b0, 16'h0004, 16'h0000, 1'b0, "fetch_1234", rc, ac, rd, be);
      check("fetch_latency", 32'(ac - rc), 32'd2);
      check("fetch_data_1234", {16'd0, rd}, 32'h1234);
      check("fetch_berr_0", {31'd0, be}, 32'd0);

      // Byte lanes on mem[3].
      do_req(0, 1'b1, 1'b0, 16'h0006, 16'h1122, 1'b0, "wr_1122", rc, ac, rd, be);
      do_req(0, 1'b1, 1'b1, 16'h0007, 16'h00FF, 1'b0, "byte_hi", rc, ac, rd, be);
      do_req(0, 1'b0, 1'b0, 16'h0006, 16'h0000, 1'b0, "fetch_ff22", rc, ac, rd, be);
      check("byte_hi_result", {16'd0, rd}, 32'hFF22);
      do_req(0, 1'b1, 1'b1, 16'h0006, 16'h0033, 1'b0, "byte_lo", rc, ac, rd, be);
      do_req(0, 1'b0, 1'b0, 16'h0006, 16'h0000, 1'b0, "fetch_ff33", rc, ac, rd, be);
      check("byte_lo_result", {16'd0, rd}, 32'hFF33);

      // Simultaneous requests: write-back first, fetch granted in the idle cycle after wb_ack.
      drive(0, 1'b1, 16'h0004, 1'b1, 16'h0004, 16'hABCD, 1'b0);
      rc = cyc;
      model_access(0, rc, 1'b1, 1'b0, 16'h0004, 16'hABCD);
      model_access(0, rc + 3, 1'b0, 1'b0, 16'h0004, 16'h0000);
      wait_ack(0, 1'b1, "race_wb", a1, rd, be);
      @(posedge clock); #1;
      drive(0, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000, 1'b0);
      wait_ack(0, 1'b0, "race_fetch", a2, rd, be);
      check("race_spacing", 32'(a2 - a1), 32'd3);
      check("race_fetch_data", {16'd0, rd}, 32'hABCD);
      @(posedge clock); #1;
      drive(0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);

      // Request dropped and inputs scrambled right after the grant edge still completes as granted.
      do_req(0, 1'b1, 1'b0, 16'h0008, 16'h0F0F, 1'b1, "drop_wr", rc, ac, rd, be);
      do_req(0, 1'b0, 1'b0, 16'h0008, 16'h0000, 1'b0, "fetch_0f0f", rc, ac, rd, be);
      check("drop_wr_result", {16'd0, rd}, 32'h0F0F);

      // Reset abort on the WAIT_CYCLES=3 instance.
      do_req(1, 1'b1, 1'b0, 16'h0010, 16'h0808, 1'b0, "d1_wr_0808", rc, ac, rd, be);
      check("d1_wr_latency", 32'(ac - rc), 32'd4);
      drive(1, 1'b0, 16'h0000, 1'b1, 16'h0010, 16'h5555, 1'b0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      rst1_n = 1'b0;
      drive(1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
      @(posedge clock); #1;
      rst1_n = 1'b1;
      repeat (6) @(posedge clock);
      #1;
      do_req(1, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, "d1_fetch", rc, ac, rd, be);
      check("d1_abort_mem_kept", {16'd0, rd}, 32'h0808);
      check("d1_fetch_latency", 32'(ac - rc), 32'd4);

      // Odd fetch and out-of-range word write.
      do_req(0, 1'b1, 1'b0, 16'h0000, 16'h7777, 1'b0, "wr_7777", rc, ac, rd, be);
      do_req(0, 1'b1, 1'b0, 16'h0002, 16'h4444, 1'b0, "wr_4444", rc, ac, rd, be);
      do_req(0, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0, "fetch_odd", rc, ac, rd, be);
`ifdef PDP_MEM_BUS_ERROR_EN
      check("odd_fetch_berr", {31'd0, be}, 32'd1);
      check("odd_fetch_data", {16'd0, rd}, 32'h0000);
`else
      check("odd_fetch_berr", {31'd0, be}, 32'd0);
      check("odd_fetch_data", {16'd0, rd}, 32'h4444);
`endif
      do_req(0, 1'b1, 1'b0, 16'h2000, 16'hBEEF, 1'b0, "wr_range", rc, ac, rd, be);
`ifdef PDP_MEM_BUS_ERROR_EN
      check("range_wr_berr", {31'd0, be}, 32'd1);
`else
      check("range_wr_berr", {31'd0, be}, 32'd0);
`endif
      do_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, "fetch_w0", rc, ac, rd, be);
`ifdef PDP_MEM_BUS_ERROR_EN
      check("range_wr_mem0", {16'd0, rd}, 32'h7777);
`else
      check("range_wr_mem0", {16'd0, rd}, 32'hBEEF);
`endif

      repeat (3) @(posedge clock);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
